// File: rtl/fc_layer_multi.sv
// Fully connected layer: streams N_IN samples and computes N_OUT dot products
// in parallel against lane-packed weights, then adds bias and optional ReLU.
module fc_layer_multi #(
    parameter int N_IN  = 225,
    parameter int N_OUT = 4,
    parameter int DW    = 22,
    parameter int WW    = 22,
    parameter int AW    = 48,
    parameter int CW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_relu_en,
    input  logic                  i_valid,
    input  logic [DW-1:0]         i_data,
    output logic                  o_ready,
    output logic [CW-1:0]         o_w_addr,
    input  logic [N_OUT*WW-1:0]   i_w_data,
    input  logic [N_OUT*WW-1:0]   i_bias,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [N_OUT*AW-1:0]   o_data
);

    typedef enum logic [1:0] {ACCUM, DRAIN, FINISH, OUT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [DW-1:0]   smp_q, smp_d;
    logic                   pv_q, pv_d;
    logic                   ready_q, ready_d;
    logic                   ovalid_q, ovalid_d;
    logic [N_OUT*AW-1:0]    odata_q, odata_d;
    logic signed [AW-1:0]   acc_q [N_OUT];
    logic signed [AW-1:0]   acc_d [N_OUT];
    logic signed [DW+WW-1:0] prod [N_OUT];
    logic signed [AW-1:0]   sum  [N_OUT];
    logic                   accept;

    assign o_ready  = ready_q;
    assign o_valid  = ovalid_q;
    assign o_data   = odata_q;
    assign o_w_addr = cnt_q;
    assign accept   = i_valid & ready_q;

    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            prod[k] = $signed(smp_q) * $signed(i_w_data[k*WW +: WW]);
            sum[k]  = acc_q[k] + AW'($signed(i_bias[k*WW +: WW]));
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        smp_d    = smp_q;
        pv_d     = 1'b0;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        acc_d    = acc_q;
        // Product of the sample held last cycle meets its weight this cycle
        if (pv_q) begin
            for (int k = 0; k < N_OUT; k++)
                acc_d[k] = acc_q[k] + AW'(prod[k]);
        end
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    smp_d = $signed(i_data);
                    pv_d  = 1'b1;
                    if (cnt_q == CW'(N_IN - 1)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: state_d = FINISH;
            FINISH: begin
                for (int k = 0; k < N_OUT; k++)
                    odata_d[k*AW +: AW] =
                        (i_relu_en && sum[k][AW-1]) ? '0 : sum[k];
                ovalid_d = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                if (i_ready) begin
                    ovalid_d = 1'b0;
                    for (int k = 0; k < N_OUT; k++) acc_d[k] = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
        if (i_clear) begin
            state_d  = ACCUM;
            cnt_d    = '0;
            pv_d     = 1'b0;
            ovalid_d = 1'b0;
            for (int k = 0; k < N_OUT; k++) acc_d[k] = '0;
        end
        ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ACCUM;
            cnt_q    <= '0;
            smp_q    <= '0;
            pv_q     <= 1'b0;
            ready_q  <= 1'b0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            for (int k = 0; k < N_OUT; k++) acc_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            smp_q    <= smp_d;
            pv_q     <= pv_d;
            ready_q  <= ready_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            for (int k = 0; k < N_OUT; k++) acc_q[k] <= acc_d[k];
        end
    end

endmodule

// File: tb/tb_fc_layer_multi.sv
// Directed bench: a small 4x2 instance for function checks and a 225-input
// instance for full-scale precision and mid-vector reset.
module tb_fc_layer_multi;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // small instance: N_IN=4, N_OUT=2
    logic        s_clear = 0, s_relu = 0, s_valid = 0, s_iready = 0;
    logic [21:0] s_data = '0;
    logic        s_ready, s_ovalid;
    logic [1:0]  s_addr;
    logic [43:0] s_wdata = '0, s_bias;
    logic [95:0] s_odata;
    logic [43:0] wm_s [4];

    fc_layer_multi #(.N_IN(4), .N_OUT(2), .DW(22), .WW(22), .AW(48)) u_small (
        .clk(clk), .rst(rst), .i_clear(s_clear), .i_relu_en(s_relu),
        .i_valid(s_valid), .i_data(s_data), .o_ready(s_ready),
        .o_w_addr(s_addr), .i_w_data(s_wdata), .i_bias(s_bias),
        .o_valid(s_ovalid), .i_ready(s_iready), .o_data(s_odata)
    );

    // large instance: 225 inputs; AW=52 holds 225*2^42 without wrapping
    logic        b_clear = 0, b_valid = 0, b_iready = 0;
    logic [21:0] b_data = '0;
    logic        b_ready, b_ovalid;
    logic [7:0]  b_addr;
    logic [43:0] b_wdata = '0;
    logic [103:0] b_odata;

    fc_layer_multi #(.N_IN(225), .N_OUT(2), .DW(22), .WW(22), .AW(52)) u_big (
        .clk(clk), .rst(rst), .i_clear(b_clear), .i_relu_en(1'b0),
        .i_valid(b_valid), .i_data(b_data), .o_ready(b_ready),
        .o_w_addr(b_addr), .i_w_data(b_wdata), .i_bias(44'd0),
        .o_valid(b_ovalid), .i_ready(b_iready), .o_data(b_odata)
    );

    // synchronous weight memories with one cycle of read latency
    always @(posedge clk) s_wdata <= wm_s[s_addr];
    always @(posedge clk) b_wdata <= {22'd1, 22'h200000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane48(input logic [47:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint lane52(input logic [51:0] v);
        return longint'($signed(v));
    endfunction

    task automatic send_small(input bit gap, input bit relu, input string tag,
                              input longint e0, input longint e1);
        int lat;
        s_relu = relu;
        for (int i = 0; i < 4; i++) begin
            if (gap) begin
                s_valid = 0;
                tick();
            end
            s_valid = 1;
            s_data  = 22'(i + 1);
            chk({tag, "_rdy"}, longint'(s_ready), 1);
            chk({tag, "_addr"}, longint'(s_addr), i);
            tick();
        end
        s_valid = 0;
        lat = 1;
        while (!s_ovalid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_l0"}, lane48(s_odata[47:0]), e0);
        chk({tag, "_l1"}, lane48(s_odata[95:48]), e1);
        chk({tag, "_rdy_out"}, longint'(s_ready), 0);
    endtask

    task automatic ack_small(input string tag);
        s_iready = 1;
        tick();
        s_iready = 0;
        chk({tag, "_ack_v"}, longint'(s_ovalid), 0);
        chk({tag, "_ack_r"}, longint'(s_ready), 1);
    endtask

    task automatic send_big(input int n, input bit wait_res, input string tag);
        int lat;
        for (int i = 0; i < n; i++) begin
            b_valid = 1;
            b_data  = 22'h200000;
            tick();
        end
        b_valid = 0;
        if (wait_res) begin
            lat = 1;
            while (!b_ovalid && lat < 20) begin
                tick();
                lat++;
            end
            chk({tag, "_lat"}, lat, 3);
            chk({tag, "_l0"}, lane52(b_odata[51:0]), 225 * (64'sd1 <<< 42));
            chk({tag, "_l1"}, lane52(b_odata[103:52]), -225 * 2097152);
            b_iready = 1;
            tick();
            b_iready = 0;
            chk({tag, "_ack"}, longint'(b_ovalid), 0);
        end
    endtask

    initial begin
        logic [95:0] held;
        for (int i = 0; i < 4; i++) wm_s[i] = {22'h000000, 22'd1};
        wm_s[0][43:22] = 22'h3FFFFF;
        wm_s[3][43:22] = 22'd2;
        s_bias = {22'h3FFFEC, 22'd10};

        // reset state
        tick();
        tick();
        chk("rst_rdy", longint'(s_ready), 0);
        chk("rst_v", longint'(s_ovalid), 0);
        chk("rst_d", longint'(s_odata != 0), 0);
        chk("rst_brdy", longint'(b_ready), 0);
        rst = 0;
        #1;
        chk("rst_rdy_hold", longint'(s_ready), 0);
        tick();
        chk("rst_rdy_rise", longint'(s_ready), 1);

        send_small(0, 0, "plain", 20, -13);
        ack_small("plain");
        send_small(0, 1, "relu", 20, 0);
        ack_small("relu");
        send_small(1, 0, "gap", 20, -13);

        // output stall
        held = s_odata;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_v", longint'(s_ovalid), 1);
            chk("stall_d", longint'(s_odata == held), 1);
            chk("stall_r", longint'(s_ready), 0);
        end
        ack_small("stall");
        send_small(0, 0, "fresh", 20, -13);
        ack_small("fresh");

        // abort after two accepts; clear wins over a same-cycle accept
        for (int i = 0; i < 2; i++) begin
            s_valid = 1;
            s_data  = 22'd100;
            tick();
        end
        s_clear = 1;
        s_data  = 22'd55;
        tick();
        s_clear = 0;
        s_valid = 0;
        chk("clr_addr", longint'(s_addr), 0);
        chk("clr_v", longint'(s_ovalid), 0);
        chk("clr_r", longint'(s_ready), 1);
        send_small(0, 0, "clr", 20, -13);
        ack_small("clr");

        // full-scale: 225 products of (-2^21)*(-2^21)
        send_big(225, 1, "big");
        send_big(100, 0, "bigpart");
        rst = 1;
        #1;
        chk("mrst_v", longint'(b_ovalid), 0);
        chk("mrst_d", longint'(b_odata != 0), 0);
        chk("mrst_r", longint'(b_ready), 0);
        tick();
        chk("mrst_addr", longint'(b_addr), 0);
        rst = 0;
        tick();
        chk("mrst_rdy", longint'(b_ready), 1);
        send_big(225, 1, "big2");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
